// File: rtl/pulse_stretcher.sv
// Turns 1-cycle internal strobes into clean off-chip pulses with guaranteed
// minimum high and low widths; strobes arriving mid-pulse are queued and replayed.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigIn,
    input  logic              clrOverflow,
    output logic              signalOut,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } stateT;

    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    stateT             state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [PEND_W-1:0] pendingNext;
    logic              overflowNext;
    logic              decision;
    logic              request;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        pendingNext  = pending;
        overflowNext = overflow & ~clrOverflow;
        decision     = (state == IDLE) || (state == LOW && cnt == LOW_LAST);
        request      = trigIn || (pending != '0);

        case (state)
            IDLE: if (request) stateNext = HIGH;
            HIGH: if (cnt == HIGH_LAST) stateNext = LOW;
            LOW:  if (cnt == LOW_LAST) stateNext = request ? HIGH : IDLE;
            default: stateNext = IDLE;
        endcase

        // The width/guard counter restarts from zero on every state entry.
        if (stateNext != state || state == IDLE)
            cntNext = '0;
        else
            cntNext = cnt + 1'b1;

        // A trigger at a decision point replaces the queued event it would have
        // consumed, so pending only moves when exactly one of the two happens.
        if (decision) begin
            if (pending != '0 && !trigIn)
                pendingNext = pending - 1'b1;
        end else if (trigIn) begin
            if (pending == PEND_MAX)
                overflowNext = 1'b1;
            else
                pendingNext = pending + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            signalOut <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            pending   <= pendingNext;
            overflow  <= overflowNext;
            signalOut <= (stateNext == HIGH);
            busy      <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HIGH=4, LOW=4, PEND_W=2). Cycle c inputs
// are sampled at the edge ending cycle c; outputs are observed mid-cycle.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigIn;
    logic       clrOverflow;
    logic       signalOut;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int passCount  = 0;
    int checkCount = 0;

    pulse_stretcher #(
        .HIGH_CYCLES(4),
        .LOW_CYCLES (4),
        .CNT_W      (8),
        .PEND_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigIn     (trigIn),
        .clrOverflow(clrOverflow),
        .signalOut  (signalOut),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {signalOut, busy, overflow, pending}.
    function automatic logic [4:0] obs();
        return {signalOut, busy, overflow, pending};
    endfunction

    task automatic doReset();
        rst         = 1'b1;
        trigIn      = 1'b0;
        clrOverflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clk);
        checkCount++;
        if (obs() !== 5'b0)
            $display("FAIL reset_state got %b exp %b", obs(), 5'b0);
        else
            passCount++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [4:0] exp;
        doReset();
        for (int c = 0; c <= 10; c++) begin
            trigIn = (c == 0);
            @(negedge clk);
            exp = {(c >= 1 && c <= 4), (c >= 1 && c <= 8), 1'b0, 2'd0};
            checkCount++;
            if (obs() !== exp)
                $display("FAIL single c=%0d got %b exp %b", c, obs(), exp);
            else
                passCount++;
            @(posedge clk);
            #1;
        end
        trigIn = 1'b0;
    endtask

    task automatic test_burst();
        logic [4:0] exp;
        logic [1:0] expPend;
        doReset();
        for (int c = 0; c <= 26; c++) begin
            trigIn = (c <= 2);
            @(negedge clk);
            if (c <= 1)       expPend = 2'd0;
            else if (c == 2)  expPend = 2'd1;
            else if (c <= 8)  expPend = 2'd2;
            else if (c <= 16) expPend = 2'd1;
            else              expPend = 2'd0;
            exp = {(c >= 1 && c <= 20 && ((c - 1) % 8) < 4), (c >= 1 && c <= 24), 1'b0, expPend};
            checkCount++;
            if (obs() !== exp)
                $display("FAIL burst c=%0d got %b exp %b", c, obs(), exp);
            else
                passCount++;
            @(posedge clk);
            #1;
        end
        trigIn = 1'b0;
    endtask

    task automatic test_decision_point();
        logic [4:0] exp;
        doReset();
        for (int c = 0; c <= 18; c++) begin
            trigIn = (c == 0 || c == 8);
            @(negedge clk);
            exp = {((c >= 1 && c <= 4) || (c >= 9 && c <= 12)), (c >= 1 && c <= 16), 1'b0, 2'd0};
            checkCount++;
            if (obs() !== exp)
                $display("FAIL decision c=%0d got %b exp %b", c, obs(), exp);
            else
                passCount++;
            @(posedge clk);
            #1;
        end
        trigIn = 1'b0;
    endtask

    task automatic test_overflow();
        logic [4:0] exp;
        logic [1:0] expPend;
        logic       prevSig;
        int         pulses;
        doReset();
        prevSig = 1'b0;
        pulses  = 0;
        for (int c = 0; c <= 36; c++) begin
            trigIn = (c <= 5);
            @(negedge clk);
            if (c <= 1)       expPend = 2'd0;
            else if (c == 2)  expPend = 2'd1;
            else if (c == 3)  expPend = 2'd2;
            else if (c <= 8)  expPend = 2'd3;
            else if (c <= 16) expPend = 2'd2;
            else if (c <= 24) expPend = 2'd1;
            else              expPend = 2'd0;
            exp = {(c >= 1 && c <= 28 && ((c - 1) % 8) < 4), (c >= 1 && c <= 32), (c >= 5), expPend};
            checkCount++;
            if (obs() !== exp)
                $display("FAIL overflow c=%0d got %b exp %b", c, obs(), exp);
            else
                passCount++;
            if (signalOut && !prevSig) pulses++;
            prevSig = signalOut;
            @(posedge clk);
            #1;
        end
        trigIn = 1'b0;
        checkCount++;
        if (pulses !== 4)
            $display("FAIL overflow_pulse_count got %0d exp %0d", pulses, 4);
        else
            passCount++;
    endtask

    // Runs straight after test_overflow so overflow is still set when rst hits.
    task automatic test_reset_mid_pulse();
        logic [4:0] exp;
        for (int c = 0; c <= 15; c++) begin
            trigIn = (c <= 2);
            rst    = (c == 3);
            @(negedge clk);
            if (c == 3)      exp = {1'b1, 1'b1, 1'b1, 2'd2};
            else if (c >= 4) exp = 5'b0;
            else             exp = obs() ^ 5'b0;
            if (c >= 3) begin
                checkCount++;
                if (obs() !== exp)
                    $display("FAIL reset_mid c=%0d got %b exp %b", c, obs(), exp);
                else
                    passCount++;
            end
            @(posedge clk);
            #1;
        end
        trigIn = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_clr_priority();
        logic expOvf;
        doReset();
        for (int c = 0; c <= 36; c++) begin
            trigIn      = (c <= 4);
            clrOverflow = (c == 4 || c == 7);
            @(negedge clk);
            expOvf = (c >= 5 && c <= 7);
            checkCount++;
            if (overflow !== expOvf)
                $display("FAIL clr_priority c=%0d got %b exp %b", c, overflow, expOvf);
            else
                passCount++;
            @(posedge clk);
            #1;
        end
        trigIn      = 1'b0;
        clrOverflow = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || pending !== 2'd0)
            $display("FAIL clr_drain got busy=%b pending=%0d exp busy=0 pending=0", busy, pending);
        else
            passCount++;
    endtask

    initial begin
        rst         = 1'b1;
        trigIn      = 1'b0;
        clrOverflow = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_decision_point();
        test_overflow();
        test_reset_mid_pulse();
        test_clr_priority();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
